audio_sample_player: RTL and testbench
======================================

Name: audio_sample_player

Overview:
- Sample-rate playback stage that feeds the sigma-delta DAC's `code` input.
- Accepts audio samples from the CPU/MMIO side over a valid/ready handshake and buffers them in a small FIFO.
- Releases exactly one sample per sample period, set by a clock-divider tick, and holds it steady on `code` for the whole period.
- On FIFO underrun, outputs midscale (silence) and counts the event.

Parameters:
- CODE_WIDTH, 10, sample/code width; must match the DAC's CODE_WIDTH.
- FIFO_DEPTH, 8, sample buffer entries; power of two, >= 2.
- CLKS_PER_SAMPLE, 2500, clock cycles per sample period (125 MHz / 2500 = 50 kHz); >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  playback enable.
- sample_data  in  CODE_WIDTH  unsigned offset-binary sample to enqueue.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  FIFO can accept a sample this cycle.
- clear_underrun  in  1  synchronous clear of underrun_count.
- code  out  CODE_WIDTH  registered sample driven to the DAC.
- sample_tick  out  1  one-cycle strobe marking each sample-period boundary.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun_count  out  16  saturating count of underrun events.

Behaviour:
- Reset (asynchronous, active-high) values:
  - code = midscale, i.e. 1 << (CODE_WIDTH-1) (512 for width 10).
  - sample_tick = 0, fifo_count = 0, underrun_count = 0.
  - Divider counter = 0; FIFO pointers = 0.
  - sample_ready = 1 immediately, since the FIFO is empty.
- Reset mid-operation discards all buffered samples.
- Write handshake:
  - A push occurs on a rising edge where sample_valid && sample_ready.
  - sample_ready = (fifo_count != FIFO_DEPTH), combinational from registered state.
  - When full, sample_ready = 0 even if a pop occurs in the same cycle; there is no full-bypass.
  - Pushes are accepted regardless of enable.
- Divider:
  - While enable = 1, the counter runs 0..CLKS_PER_SAMPLE-1 and wraps to 0.
  - sample_tick is registered and asserted for exactly the one cycle after the counter reaches CLKS_PER_SAMPLE-1.
  - Result: one tick every CLKS_PER_SAMPLE cycles; the first tick comes CLKS_PER_SAMPLE cycles after enable rises.
  - enable = 0 holds the counter at 0 and forces sample_tick = 0.
- Pop on tick (evaluated in the cycle sample_tick = 1):
  - FIFO non-empty: pop the head; code takes its value at the next edge. Latency tick -> code update = 1 cycle.
  - FIFO empty: code <= midscale; underrun_count increments by 1, saturating at 0xFFFF.
  - A push in the same cycle as an underrun pop does not bypass: the underrun still counts, and the pushed sample is played on the following tick.
  - A push and a pop in the same cycle leave fifo_count unchanged.
- code holds its value between ticks. enable falling sets code <= midscale on the next edge; FIFO contents are retained.
- clear_underrun = 1 zeroes underrun_count at the next edge. If clear and increment fall in the same cycle, clear wins (result 0).
- Ordering is strict FIFO. Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with the extra count bit, so full and empty are unambiguous.

Decomposition:
- Shared audio package holds:
  - midscale constant function midscale(CODE_WIDTH).
  - default CLKS_PER_SAMPLE for the 50 kHz rate.
  - UNDERRUN_CNT_WIDTH = 16.
- One natural sub-module: sync_fifo. It is parameterised on WIDTH/DEPTH and has push/pop, full/empty and count outputs.
- The divider, pop control and underrun counter stay in the top module.

Test Plan:
All scenarios use CODE_WIDTH=10, FIFO_DEPTH=4, CLKS_PER_SAMPLE=5.
1. Reset, then enable=1 with no writes -> code=512 throughout; ticks at cycles 5, 10, 15; underrun_count reads 1, 2, 3.
2. Push 100, 200, 300 with enable=0, then enable=1 -> fifo_count=3 before enable; code becomes 100, 200, 300 one cycle after successive ticks; 4th tick gives code=512 and underrun_count=1.
3. Push 5 samples back-to-back with sample_valid held high -> 4 accepted, sample_ready=0 on the 5th until the first pop; the 5th sample is accepted the cycle after the pop; playback order is preserved.
4. Assert clear_underrun in the same cycle as an underrun tick while underrun_count=7 -> next value is 0.
5. Preload underrun_count to 0xFFFF (force), then run an empty FIFO for 3 ticks -> count stays 0xFFFF.
6. With 2 samples buffered and code=100, assert rst asynchronously mid-period -> outputs take reset values immediately (code=512, fifo_count=0); after release, the next tick underruns.

Source files
------------

// File: rtl/audio_sample_player_pkg.sv
// Shared constants and helpers for the audio playback path.
package audio_sample_player_pkg;

    localparam int DEFAULT_CLKS_PER_SAMPLE = 2500;  // 125 MHz / 50 kHz
    localparam int UNDERRUN_CNT_WIDTH      = 16;

    // Offset-binary silence level for a code of the given width.
    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/audio_sample_player_sync_fifo.sv
// Single-clock FIFO with an extra occupancy bit so full and empty are unambiguous.
module audio_sample_player_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Guard here as well so a careless caller cannot corrupt the pointers.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_player.sv
// Buffers CPU-written samples and releases one per sample period to the DAC code input,
// playing silence and counting an underrun whenever the buffer is empty at a period boundary.
module audio_sample_player
    import audio_sample_player_pkg::*;
#(
    parameter int CODE_WIDTH      = 10,
    parameter int FIFO_DEPTH      = 8,
    parameter int CLKS_PER_SAMPLE = DEFAULT_CLKS_PER_SAMPLE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [CODE_WIDTH-1:0]         sample_data,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    input  logic                          clear_underrun,
    output logic [CODE_WIDTH-1:0]         code,
    output logic                          sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [UNDERRUN_CNT_WIDTH-1:0] underrun_count
);

    localparam int                    DIV_W    = $clog2(CLKS_PER_SAMPLE);
    localparam logic [CODE_WIDTH-1:0] MIDSCALE = CODE_WIDTH'(midscale(CODE_WIDTH));

    logic [DIV_W-1:0]              r_div_cnt;
    logic                          r_tick;
    logic [CODE_WIDTH-1:0]         r_code;
    logic [UNDERRUN_CNT_WIDTH-1:0] r_underrun_cnt;

    logic                          w_full;
    logic                          w_empty;
    logic [CODE_WIDTH-1:0]         w_head;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_underrun;

    // No full-bypass: ready depends only on registered occupancy.
    assign sample_ready = ~w_full;
    assign w_push       = sample_valid & ~w_full;
    assign w_pop        = r_tick & enable & ~w_empty;
    assign w_underrun   = r_tick & enable & w_empty;

    audio_sample_player_sync_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (sample_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Tick lands one cycle after the counter reaches its terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (!enable) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (r_div_cnt == DIV_W'(CLKS_PER_SAMPLE - 1)) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
            r_tick    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_code <= MIDSCALE;
        end else if (!enable) begin
            r_code <= MIDSCALE;
        end else if (w_pop) begin
            r_code <= w_head;
        end else if (w_underrun) begin
            r_code <= MIDSCALE;
        end
    end

    // Clear takes priority over a coincident underrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (clear_underrun) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun && (r_underrun_cnt != '1)) begin
            r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_WIDTH'(1);
        end
    end

    assign code           = r_code;
    assign sample_tick    = r_tick;
    assign underrun_count = r_underrun_cnt;

endmodule

// File: tb/tb_audio_sample_player.sv
// Directed bench for audio_sample_player with a 4-deep FIFO and a 5-cycle sample period.
module tb_audio_sample_player;

    localparam int CW  = 10;
    localparam int FD  = 4;
    localparam int CPS = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [CW-1:0] sample_data = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic          clear_underrun = 1'b0;
    logic [CW-1:0] code;
    logic          sample_tick;
    logic [2:0]    fifo_count;
    logic [15:0]   underrun_count;

    int n_checks = 0;
    int n_pass   = 0;

    audio_sample_player #(
        .CODE_WIDTH      (CW),
        .FIFO_DEPTH      (FD),
        .CLKS_PER_SAMPLE (CPS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .clear_underrun (clear_underrun),
        .code           (code),
        .sample_tick    (sample_tick),
        .fifo_count     (fifo_count),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance past one rising edge; inputs are driven and outputs sampled 1 time unit after it.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        enable         = 1'b0;
        sample_valid   = 1'b0;
        clear_underrun = 1'b0;
        rst            = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic push(input logic [CW-1:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
    endtask

    initial begin
        // Scenario 1: reset values, then empty playback
        step(2);
        rst = 1'b0;
        check("rst_code",  32'(code), 32'd512);
        check("rst_tick",  32'(sample_tick), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ur",    32'(underrun_count), 32'd0);
        check("rst_ready", 32'(sample_ready), 32'd1);
        enable = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check("s1_tick", 32'(sample_tick), 32'((i % CPS) == 0));
            check("s1_code", 32'(code), 32'd512);
            check("s1_ur",   32'(underrun_count), 32'((i - 1) / CPS));
        end
        $display("scenario 1: empty playback, underrun_count=%0d", underrun_count);

        // Scenario 2: preload three samples while disabled
        do_reset();
        push(10'd100);
        push(10'd200);
        push(10'd300);
        check("s2_count_pre", 32'(fifo_count), 32'd3);
        enable = 1'b1;
        step(5);
        check("s2_tick1",  32'(sample_tick), 32'd1);
        check("s2_code_t", 32'(code), 32'd512);
        step(1);
        check("s2_code1",  32'(code), 32'd100);
        check("s2_count1", 32'(fifo_count), 32'd2);
        step(4);
        check("s2_hold",   32'(code), 32'd100);
        step(1);
        check("s2_code2",  32'(code), 32'd200);
        step(5);
        check("s2_code3",  32'(code), 32'd300);
        step(5);
        check("s2_code4",  32'(code), 32'd512);
        check("s2_ur",     32'(underrun_count), 32'd1);
        check("s2_count4", 32'(fifo_count), 32'd0);
        $display("scenario 2: played 100/200/300 then underrun");

        // Scenario 3: overfill, no full-bypass, order preserved
        do_reset();
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample_data = 10'(11 + i);
            step(1);
        end
        sample_data = 10'd15;
        check("s3_full_cnt",   32'(fifo_count), 32'd4);
        check("s3_full_ready", 32'(sample_ready), 32'd0);
        enable = 1'b1;
        step(5);
        check("s3_tick_ready", 32'(sample_ready), 32'd0);
        check("s3_tick_cnt",   32'(fifo_count), 32'd4);
        step(1);
        check("s3_pop_code",   32'(code), 32'd11);
        check("s3_pop_cnt",    32'(fifo_count), 32'd3);
        check("s3_pop_ready",  32'(sample_ready), 32'd1);
        step(1);
        sample_valid = 1'b0;
        check("s3_acc_cnt",    32'(fifo_count), 32'd4);
        step(4);
        check("s3_code12", 32'(code), 32'd12);
        step(5);
        check("s3_code13", 32'(code), 32'd13);
        step(5);
        check("s3_code14", 32'(code), 32'd14);
        step(5);
        check("s3_code15", 32'(code), 32'd15);
        step(5);
        check("s3_code_mid", 32'(code), 32'd512);
        check("s3_ur",       32'(underrun_count), 32'd1);
        $display("scenario 3: overfill accepted 5 samples in order");

        // Scenario 4: clear coincident with an underrun
        do_reset();
        enable = 1'b1;
        step(40);
        check("s4_ur7",  32'(underrun_count), 32'd7);
        check("s4_tick", 32'(sample_tick), 32'd1);
        clear_underrun = 1'b1;
        step(1);
        clear_underrun = 1'b0;
        check("s4_clear", 32'(underrun_count), 32'd0);
        $display("scenario 4: clear wins over underrun increment");

        // Scenario 5: saturation
        do_reset();
        force dut.r_underrun_cnt = 16'hFFFF;
        step(1);
        release dut.r_underrun_cnt;
        step(1);
        check("s5_pre", 32'(underrun_count), 32'hFFFF);
        enable = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step(CPS);
            step(1);
            check("s5_sat", 32'(underrun_count), 32'hFFFF);
        end
        $display("scenario 5: underrun_count saturates at 0xFFFF");

        // Scenario 6: asynchronous reset mid-period
        do_reset();
        push(10'd100);
        push(10'd200);
        push(10'd250);
        enable = 1'b1;
        step(6);
        check("s6_code_pre",  32'(code), 32'd100);
        check("s6_count_pre", 32'(fifo_count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("s6_async_code",  32'(code), 32'd512);
        check("s6_async_count", 32'(fifo_count), 32'd0);
        check("s6_async_ready", 32'(sample_ready), 32'd1);
        step(1);
        rst = 1'b0;
        step(5);
        check("s6_tick", 32'(sample_tick), 32'd1);
        step(1);
        check("s6_code_post", 32'(code), 32'd512);
        check("s6_ur_post",   32'(underrun_count), 32'd1);
        $display("scenario 6: async reset discarded buffered samples");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
